// File: rtl/piece_motion_ctrl.sv
// Falling-piece position controller: synchronises the buttons and the gravity tick,
// queues requests, and commits moves only on the vsync falling edge.
module piece_motion_ctrl #(
    parameter logic [9:0] CELL    = 10'd20,
    parameter logic [9:0] X_MIN   = 10'd200,
    parameter logic [9:0] X_MAX   = 10'd420,
    parameter logic [9:0] Y_TOP   = 10'd20,
    parameter logic [9:0] Y_MAX   = 10'd440,
    parameter logic [9:0] SPAWN_X = 10'd300
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       left,
    input  logic       right,
    input  logic       down,
    input  logic       up,
    input  logic       fall_down_clk,
    input  logic       start_over,
    input  logic       vs,
    input  logic       stop,
    input  logic       hit,
    output logic [9:0] x_cor,
    output logic [9:0] y_cor,
    output logic       change_shape,
    output logic       rotate,
    output logic       landed,
    output logic       game_over
);

    localparam logic [1:0] SPAWN  = 2'd0;
    localparam logic [1:0] FALL   = 2'd1;
    localparam logic [1:0] LANDED = 2'd2;
    localparam logic [1:0] OVER   = 2'd3;

    // Bit order shared by sync chain, edges and pending flags: L, R, D, U, tick, start_over.
    localparam int B_L = 0, B_R = 1, B_D = 2, B_U = 3, B_T = 4, B_S = 5;

    logic [1:0] state;
    logic [5:0] sy1, sy2, sy3, edg;
    logic [4:0] pend;
    logic       vs_q, fb;

    assign edg       = sy2 & ~sy3;
    assign fb        = vs_q & ~vs;
    assign game_over = (state == OVER);

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state        <= SPAWN;
            sy1          <= '0;
            sy2          <= '0;
            sy3          <= '0;
            vs_q         <= 1'b0;
            pend         <= '0;
            x_cor        <= SPAWN_X;
            y_cor        <= Y_TOP;
            change_shape <= 1'b0;
            rotate       <= 1'b0;
            landed       <= 1'b0;
        end else begin
            sy1          <= {start_over, fall_down_clk, up, down, right, left};
            sy2          <= sy1;
            sy3          <= sy2;
            vs_q         <= vs;
            change_shape <= 1'b0;
            rotate       <= 1'b0;
            landed       <= 1'b0;
            pend         <= pend | edg[4:0];

            if (edg[B_S]) begin
                state <= SPAWN;
            end else begin
                case (state)
                    SPAWN: begin
                        x_cor        <= SPAWN_X;
                        y_cor        <= Y_TOP;
                        change_shape <= 1'b1;
                        pend         <= '0;
                        state        <= FALL;
                    end
                    FALL: if (fb) begin
                        // Everything queued is consumed; only edges landing this cycle survive.
                        pend <= edg[4:0];
                        if (pend[B_L] && !pend[B_R] && !hit && x_cor > X_MIN)
                            x_cor <= x_cor - CELL;
                        else if (pend[B_R] && !pend[B_L] && !hit && x_cor < X_MAX)
                            x_cor <= x_cor + CELL;
                        rotate <= pend[B_U];
                        if (pend[B_T] || pend[B_D]) begin
                            if (stop || y_cor == Y_MAX)
                                state <= LANDED;
                            else
                                y_cor <= y_cor + CELL;
                        end
                    end
                    LANDED: begin
                        landed <= 1'b1;
                        state  <= (y_cor == Y_TOP) ? OVER : SPAWN;
                    end
                    default: pend <= '0;
                endcase
            end
        end
    end

endmodule
